// File: rtl/reg_wb_sequencer.sv
// -----------------------------------------------------------------------------
// reg_wb_sequencer
//
// Writer-side front end of the register file's single write port. Two result
// streams (ALU "A" and load unit "M") are merged by a round-robin arbiter into
// at most one write per cycle. The write is registered, so wb_* present the
// write one cycle after the accept. A per-register busy scoreboard lets decode
// detect RAW hazards and reserve destination registers.
//
// Handshake: a source holds x_valid and its rd/data stable until it sees
// x_ready=1 in the same cycle. The accept happens on the rising edge that
// closes that cycle. alloc_valid/alloc_ready follow the same rule.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   a_valid/a_ready/a_rd/a_data   ALU result stream
//   m_valid/m_ready/m_rd/m_data   load result stream
//   alloc_valid/alloc_rd/alloc_ready  destination reservation from decode
//   q_rs1/q_rs2 -> busy1/busy2    combinational hazard queries
//   flush                         drops all reservations on the next edge
//   wb_we/wb_addr/wb_data         register file write port (we3/a3/wd)
//
// Build option
//   WB_CHECK_EN  when defined, an accepted write to a register that holds no
//                reservation raises $error and sets the sticky flag
//                err_unalloc_q; an alloc to x0 raises $warning.
// -----------------------------------------------------------------------------
module reg_wb_sequencer #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [AW-1:0]   a_rd,
   input  logic [XLEN-1:0] a_data,
   input  logic            m_valid,
   output logic            m_ready,
   input  logic [AW-1:0]   m_rd,
   input  logic [XLEN-1:0] m_data,
   input  logic            alloc_valid,
   input  logic [AW-1:0]   alloc_rd,
   output logic            alloc_ready,
   input  logic [AW-1:0]   q_rs1,
   input  logic [AW-1:0]   q_rs2,
   output logic            busy1,
   output logic            busy2,
   input  logic            flush,
   output logic            wb_we,
   output logic [AW-1:0]   wb_addr,
   output logic [XLEN-1:0] wb_data
);

   // Arbiter memory: 1 means the load port won the most recent tie.
   logic            rr_last_q;
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   logic            grant_a;
   logic            grant_m;
   logic            acc;
   logic [AW-1:0]   acc_rd;
   logic [XLEN-1:0] acc_data;

   // ---------------------------------------------------------------- arbiter
   always_comb begin
      grant_a = a_valid & (~m_valid | rr_last_q);
      grant_m = m_valid & (~a_valid | ~rr_last_q);
   end

   assign a_ready = a_valid & grant_a;
   assign m_ready = m_valid & grant_m;
   assign acc     = a_ready | m_ready;

   always_comb begin
      acc_rd   = a_rd;
      acc_data = a_data;
      if (m_ready) begin
         acc_rd   = m_rd;
         acc_data = m_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q <= 1'b1;
      end else if (a_valid && m_valid) begin
         // Only a real contest moves the pointer; lone requests leave it alone.
         rr_last_q <= grant_m;
      end
   end

   // -------------------------------------------------------- write-back regs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_we   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else if (acc) begin
         // x0 results are consumed but never reach the register file.
         wb_we   <= (acc_rd != '0);
         wb_addr <= acc_rd;
         wb_data <= acc_data;
      end else begin
         wb_we   <= 1'b0;
      end
   end

   // ------------------------------------------------------------- scoreboard
   assign alloc_ready = alloc_valid & ((alloc_rd == '0) | ~busy_q[alloc_rd]);

   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         if (acc && (acc_rd != '0)) begin
            busy_d[acc_rd] = 1'b0;
         end
         // Applied after the clear so a same-edge reservation survives.
         if (alloc_ready && (alloc_rd != '0)) begin
            busy_d[alloc_rd] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // busy_q[0] is held at zero, the explicit test only keeps the intent visible.
   assign busy1 = busy_q[q_rs1] & (q_rs1 != '0);
   assign busy2 = busy_q[q_rs2] & (q_rs2 != '0);

`ifdef WB_CHECK_EN
   // ------------------------------------------------------------- checking
   logic err_unalloc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_unalloc_q <= 1'b0;
      end else if (acc && (acc_rd != '0) && !busy_q[acc_rd]) begin
         err_unalloc_q <= 1'b1;
         $error("[%0t] write to unreserved register: port=%s rd=%0d",
                $time, m_ready ? "M" : "A", acc_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && alloc_valid && (alloc_rd == '0)) begin
         $warning("[%0t] alloc to x0 requested", $time);
      end
   end
`endif

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_sequencer
//
// Table of arbitration vectors (inputs plus expected ready bits) applied in
// order from reset, plus hand-written sequences for reset, hazard scoreboard,
// flush, x0 and set-wins corners. Each driven cycle pushes the expected
// write-back tuple {we, addr, data} onto exp_q; it is popped and compared one
// edge later against wb_*.
// -----------------------------------------------------------------------------
module tb_reg_wb_sequencer;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   // ---------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            a_valid, m_valid, alloc_valid, flush;
   logic [AW-1:0]   a_rd, m_rd, alloc_rd, q_rs1, q_rs2;
   logic [XLEN-1:0] a_data, m_data;
   logic            a_ready, m_ready, alloc_ready, busy1, busy2;
   logic            wb_we;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;

   reg_wb_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .busy1(busy1), .busy2(busy2),
      .flush(flush),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   // ------------------------------------------------------------ scoreboard
   int checks = 0;
   int errors = 0;
   logic [XLEN+AW:0] exp_q[$];
   logic [AW-1:0]    mdl_addr;
   logic [XLEN-1:0]  mdl_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------- driver tasks
   task automatic idle();
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      m_valid = 1'b0; m_rd = '0; m_data = '0;
      alloc_valid = 1'b0; alloc_rd = '0; flush = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      mdl_addr = '0;
      mdl_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Inputs are already driven; checks the ready bits, pushes the expected
   // write-back, clocks once and compares wb_* against the popped entry.
   task automatic step(input string name, input logic ea, input logic em);
      logic [XLEN+AW:0] e;
      #1;
      chk({name, " a_ready"}, {31'b0, a_ready}, {31'b0, ea});
      chk({name, " m_ready"}, {31'b0, m_ready}, {31'b0, em});
      if (ea) begin
         mdl_addr = a_rd; mdl_data = a_data;
         e = {a_rd != '0, a_rd, a_data};
      end else if (em) begin
         mdl_addr = m_rd; mdl_data = m_data;
         e = {m_rd != '0, m_rd, m_data};
      end else begin
         e = {1'b0, mdl_addr, mdl_data};
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({name, " wb_we"},   {31'b0, wb_we},   {31'b0, e[XLEN+AW]});
      chk({name, " wb_addr"}, {27'b0, wb_addr}, {27'b0, e[XLEN+AW-1:XLEN]});
      chk({name, " wb_data"}, wb_data,          e[XLEN-1:0]);
   endtask

   // ------------------------------------------------------------ vectors
   typedef struct {
      logic            av;
      logic [AW-1:0]   ar;
      logic [XLEN-1:0] ad;
      logic            mv;
      logic [AW-1:0]   mr;
      logic [XLEN-1:0] md;
      logic            ea;
      logic            em;
   } vec_t;

   vec_t vecs[10];

   initial begin
      // Applied in order straight after reset (A wins the first tie).
      vecs[0] = '{1'b1, 5'd1, 32'h0000_000A, 1'b1, 5'd2, 32'h0000_000B, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_000B, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 5'd1, 32'h0000_00A2, 1'b1, 5'd2, 32'h0000_00B1, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd4, 32'h0000_000C, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 1'b0};
      vecs[6] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0};
      vecs[7] = '{1'b1, 5'd6, 32'h0000_000D, 1'b1, 5'd0, 32'h0000_000E, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 5'd6, 32'h0000_00D2, 1'b1, 5'd0, 32'h0000_000E, 1'b0, 1'b1};
      vecs[9] = '{1'b1, 5'd6, 32'h0000_00D2, 1'b1, 5'd8, 32'h0000_000F, 1'b1, 1'b0};

      q_rs1 = '0;
      q_rs2 = '0;
      do_reset();

      // Reset state
      chk("rst wb_we",   {31'b0, wb_we},   32'd0);
      chk("rst wb_addr", {27'b0, wb_addr}, 32'd0);
      chk("rst wb_data", wb_data,          32'd0);
      q_rs1 = 5'd5; q_rs2 = 5'd31;
      #1;
      chk("rst busy1", {31'b0, busy1}, 32'd0);
      chk("rst busy2", {31'b0, busy2}, 32'd0);

      // Single ALU write with hazard visibility
      alloc_valid = 1'b1; alloc_rd = 5'd5;
      #1;
      chk("alloc5 ready", {31'b0, alloc_ready}, 32'd1);
      step("alloc5", 1'b0, 1'b0);
      idle();
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234_5678;
      #1;
      chk("alu5 busy1 before", {31'b0, busy1}, 32'd1);
      step("alu5", 1'b1, 1'b0);
      chk("alu5 busy1 after", {31'b0, busy1}, 32'd0);
      idle();

      // Arbitration table
      do_reset();
      for (int i = 0; i < 10; i++) begin
         a_valid = vecs[i].av; a_rd = vecs[i].ar; a_data = vecs[i].ad;
         m_valid = vecs[i].mv; m_rd = vecs[i].mr; m_data = vecs[i].md;
         step($sformatf("vec%0d", i), vecs[i].ea, vecs[i].em);
      end
      idle();

      // x0 handling: alloc and result to x0 leave no trace
      q_rs1 = 5'd0;
      alloc_valid = 1'b1; alloc_rd = 5'd0;
      #1;
      chk("x0 alloc ready", {31'b0, alloc_ready}, 32'd1);
      step("x0 alloc", 1'b0, 1'b0);
      chk("x0 busy1 a", {31'b0, busy1}, 32'd0);
      idle();
      a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
      step("x0 result", 1'b1, 1'b0);
      chk("x0 busy1 b", {31'b0, busy1}, 32'd0);
      idle();

      // Alloc stall and flush (result accepted in flush cycle still written)
      q_rs2 = 5'd7;
      alloc_valid = 1'b1; alloc_rd = 5'd7;
      #1;
      chk("alloc7 ready", {31'b0, alloc_ready}, 32'd1);
      step("alloc7", 1'b0, 1'b0);
      chk("alloc7 stall ready", {31'b0, alloc_ready}, 32'd0);
      chk("alloc7 busy2", {31'b0, busy2}, 32'd1);
      step("alloc7 stall", 1'b0, 1'b0);
      flush = 1'b1;
      a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h0000_0077;
      step("flush", 1'b1, 1'b0);
      flush = 1'b0; a_valid = 1'b0;
      #1;
      chk("flush busy2", {31'b0, busy2}, 32'd0);
      chk("realloc7 ready", {31'b0, alloc_ready}, 32'd1);
      step("realloc7", 1'b0, 1'b0);
      chk("realloc7 busy2", {31'b0, busy2}, 32'd1);
      idle();

      // Same-edge alloc and clear of one register: reservation kept
      q_rs1 = 5'd3;
      alloc_valid = 1'b1; alloc_rd = 5'd3;
      m_valid = 1'b1; m_rd = 5'd3; m_data = 32'h0000_0033;
      step("setwins", 1'b0, 1'b1);
      chk("setwins busy1", {31'b0, busy1}, 32'd1);
      idle();
      m_valid = 1'b1; m_rd = 5'd3; m_data = $urandom_range(1, 32'h7FFF_FFFF);
      step("clr3", 1'b0, 1'b1);
      chk("clr3 busy1", {31'b0, busy1}, 32'd0);
      idle();

      // Reset in the middle of a write
      alloc_valid = 1'b1; alloc_rd = 5'd6;
      step("alloc6", 1'b0, 1'b0);
      idle();
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h0000_0055;
      step("pre_rst", 1'b1, 1'b0);
      idle();
      q_rs1 = 5'd6;
      #1;
      chk("pre_rst busy1", {31'b0, busy1}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst wb_we",   {31'b0, wb_we},   32'd0);
      chk("midrst wb_addr", {27'b0, wb_addr}, 32'd0);
      chk("midrst busy1",   {31'b0, busy1},   32'd0);
      chk("exp_q drained",  exp_q.size(),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ------------------------------------------------------------ report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
